adc_trigger_capture: RTL and testbench
======================================

# adc_trigger_capture

Triggered ADC snapshot buffer between the ADC1175 sample register and the serial transmitter. After an arm pulse it watches the 12 MHz sample stream for a level crossing, stores a fixed-length burst of consecutive samples in on-chip RAM, then replays the burst byte-by-byte to `serial_tx` under a send/done handshake. This replaces the free-running "one sample every 12 clocks" feed with a coherent, gap-free capture.

## Interface
- `DEPTH`, 256: samples per capture; power of two, 16..1024.
- `ADDR_W`, 8: log2(DEPTH).
- `clk12`  in  1: 12 MHz system clock, same clock as ADC_CLK and `serial_tx`.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `adc_d`  in  8: registered ADC sample, new value every `clk12` cycle.
- `arm`  in  1: one-cycle pulse; starts a capture from IDLE.
- `trig_level`  in  8: trigger threshold, unsigned.
- `trig_rising`  in  1: 1 = rising-edge trigger, 0 = falling-edge trigger.
- `sbyte`  out  8: byte to transmit.
- `sbyte_rdy`  out  1: one-cycle pulse; `sbyte` is valid.
- `tx_done`  in  1: one-cycle pulse from `serial_tx` `end_of_send`.
- `busy`  out  1: high in any state except IDLE.
- `armed`  out  1: high in ARMED only (LED indicator).

## Operation
- States: IDLE, ARMED, CAPTURE, DUMP_RD, DUMP_WAIT.
- IDLE: `arm`=1 -> ARMED, history-valid flag cleared. `arm` is ignored in all other states.
- ARMED: `prev_d` <= `adc_d` every cycle; history-valid set after the first ARMED cycle. Trigger only when history valid:
  - rising: `prev_d < trig_level` and `adc_d >= trig_level`;
  - falling: `prev_d > trig_level` and `adc_d <= trig_level`.
- On trigger: the triggering `adc_d` is written to address 0 on the same edge, `wr_addr` <= 1, -> CAPTURE.
- CAPTURE: write `adc_d` to `wr_addr` each cycle, increment. After writing address DEPTH-1 -> DUMP_RD, `rd_addr` <= 0. No wrap; exactly DEPTH samples.
- DUMP_RD: RAM read latency is 1 cycle. Next cycle: `sbyte` <= RAM data, `sbyte_rdy` pulses, -> DUMP_WAIT.
- DUMP_WAIT: `sbyte` held stable. On `tx_done`: if `rd_addr` = DEPTH-1 -> IDLE; else `rd_addr`+1, -> DUMP_RD. No timeout; waits indefinitely.
- A `tx_done` on the same cycle as `sbyte_rdy` is ignored; only `tx_done` pulses strictly after `sbyte_rdy` count.
- `trig_level` and `trig_rising` are sampled live in ARMED; they have no effect in other states.

## Timing
- Reset values: `sbyte`=0, `sbyte_rdy`=0, `busy`=0, `armed`=0, state IDLE, all address counters 0. RAM contents are not cleared.
- Reset mid-capture or mid-dump aborts immediately. The next arm starts a fresh capture.
- `arm` at edge t -> `armed`=1 after edge t. Earliest trigger is at edge t+2, because one history sample is needed.
- Trigger at edge T -> sample written at address k is `adc_d` at edge T+k; CAPTURE is left at edge T+DEPTH-1.
- First `sbyte_rdy` is high 2 cycles after CAPTURE ends. Gap from `tx_done` to the next `sbyte_rdy` is exactly 2 cycles.
- `sbyte_rdy` is high for exactly one cycle per byte.

## Configuration
- `ADC_CAP_HEADER_EN` defined: each dump is prefixed by two header bytes, 0xA5 then 0x5A. Each header byte uses the same pulse/`tx_done` handshake before RAM byte 0. The dump is DEPTH+2 bytes.
- `ADC_CAP_HEADER_EN` undefined: the dump is exactly DEPTH bytes, starting with RAM address 0.

## Structure
- Package `adc_cap_pkg` holds:
  - the state enumeration;
  - header constants `HDR0`=8'hA5 and `HDR1`=8'h5A;
  - defaults for `DEPTH` and `ADDR_W`.
- One sub-module, `adc_cap_ram`: simple dual-port synchronous RAM, DEPTH×8, one write port and one registered read port, single clock `clk12`. It infers an M9K block.
- The FSM, trigger comparator and header sequencing live in `adc_trigger_capture`.

## Test plan
- Rising trigger: `trig_level`=0x80, `trig_rising`=1, ramp `adc_d` 0x00..0xFF by +1 per cycle after `arm`. The first RAM byte sent is 0x80, followed by 0x81.., 256 bytes total. The last byte is 0x7F after wrap of the ramp.
- Falling trigger: `trig_rising`=0, `trig_level`=0x40, descending ramp from 0xFF. The first byte sent is 0x40. A rising crossing before it does not trigger.
- No history: `arm` while `adc_d` is already at 0x90 with `trig_level`=0x80, held constant. No trigger occurs and `armed` stays 1. Drop the input to 0x10 then 0x90: the trigger fires on the 0x90 sample.
- Handshake: `tx_done` returned with random 1..40 cycle delays. Check:
  - exactly one `sbyte_rdy` per `tx_done`;
  - `sbyte` stable between them;
  - a `tx_done` coincident with `sbyte_rdy` does not advance the dump.
- Reset mid-dump: assert `rst_n`=0 after byte 100. All outputs read 0 and the state is IDLE. A re-arm yields a full new dump of DEPTH bytes.
- With `ADC_CAP_HEADER_EN` defined: the first two bytes are 0xA5, 0x5A, the total is 258 bytes, and `busy` falls 1 cycle after the final `tx_done`.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared states, header bytes and size defaults for the ADC capture block
package adc_cap_pkg;

  localparam int DEPTH_DEF  = 256;
  localparam int ADDR_W_DEF = 8;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DUMP_RD,
    S_DUMP_WAIT
  } state_t;

endpackage

// File: rtl/adc_cap_ram.sv
// rtl/adc_cap_ram.sv - DEPTHx8 simple dual-port RAM, one write port, registered read port
module adc_cap_ram
  import adc_cap_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk12,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  // Unreset storage with a registered read so it maps onto a block RAM
  always_ff @(posedge clk12) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// rtl/adc_trigger_capture.sv - level-crossing triggered ADC burst capture and byte replay (option: ADC_CAP_HEADER_EN adds an A5/5A dump header)
module adc_trigger_capture
  import adc_cap_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic       clk12,
  input  logic       rst_n,
  input  logic [7:0] adc_d,
  input  logic       arm,
  input  logic [7:0] trig_level,
  input  logic       trig_rising,
  output logic [7:0] sbyte,
  output logic       sbyte_rdy,
  input  logic       tx_done,
  output logic       busy,
  output logic       armed
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic [7:0]        prev_d, prev_n;
  logic              hist_valid, hist_n;
  logic              rd_wait, rd_wait_n;
  logic [7:0]        sbyte_n;
  logic              rdy_n;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [7:0]        rd_data;
  logic              trig_hit;
  logic              tx_accept;
  logic              hdr_done;
  logic [7:0]        dump_byte;

  adc_cap_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk12   (clk12),
    .we      (ram_we),
    .wr_addr (ram_wa),
    .wr_data (adc_d),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign trig_hit = trig_rising ? ((prev_d < trig_level) && (adc_d >= trig_level))
                                : ((prev_d > trig_level) && (adc_d <= trig_level));
  // A tx_done landing in the same cycle as the byte pulse belongs to the previous byte
  assign tx_accept = tx_done && !sbyte_rdy;
  assign busy      = (state != S_IDLE);
  assign armed     = (state == S_ARMED);

`ifdef ADC_CAP_HEADER_EN
  logic [1:0] hdr_idx;

  assign hdr_done  = (hdr_idx == 2'd2);
  assign dump_byte = hdr_done ? rd_data : ((hdr_idx == 2'd0) ? HDR0 : HDR1);

  // Header byte index: restarts at the end of each capture, steps per acknowledged header byte
  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx <= 2'd0;
    end else if (state == S_CAPTURE && wr_addr == LAST) begin
      hdr_idx <= 2'd0;
    end else if (state == S_DUMP_WAIT && tx_accept && !hdr_done) begin
      hdr_idx <= hdr_idx + 2'd1;
    end
  end
`else
  assign hdr_done  = 1'b1;
  assign dump_byte = rd_data;
`endif

  // State and datapath registers
  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      prev_d     <= 8'h00;
      hist_valid <= 1'b0;
      rd_wait    <= 1'b0;
      sbyte      <= 8'h00;
      sbyte_rdy  <= 1'b0;
    end else begin
      state      <= state_n;
      wr_addr    <= wr_addr_n;
      rd_addr    <= rd_addr_n;
      prev_d     <= prev_n;
      hist_valid <= hist_n;
      rd_wait    <= rd_wait_n;
      sbyte      <= sbyte_n;
      sbyte_rdy  <= rdy_n;
    end
  end

  // Next-state, RAM write control and dump sequencing
  always_comb begin
    state_n   = state;
    wr_addr_n = wr_addr;
    rd_addr_n = rd_addr;
    prev_n    = prev_d;
    hist_n    = hist_valid;
    rd_wait_n = rd_wait;
    sbyte_n   = sbyte;
    rdy_n     = 1'b0;
    ram_we    = 1'b0;
    ram_wa    = wr_addr;
    case (state)
      S_IDLE: begin
        if (arm) begin
          state_n = S_ARMED;
          hist_n  = 1'b0;
        end
      end
      S_ARMED: begin
        prev_n = adc_d;
        hist_n = 1'b1;
        if (hist_valid && trig_hit) begin
          ram_we    = 1'b1;
          ram_wa    = '0;
          wr_addr_n = ADDR_W'(1);
          state_n   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        ram_we    = 1'b1;
        wr_addr_n = wr_addr + 1'b1;
        if (wr_addr == LAST) begin
          rd_addr_n = '0;
          rd_wait_n = 1'b0;
          state_n   = S_DUMP_RD;
        end
      end
      S_DUMP_RD: begin
        // First cycle lets the registered RAM read settle, second presents the byte
        if (!rd_wait) begin
          rd_wait_n = 1'b1;
        end else begin
          rd_wait_n = 1'b0;
          sbyte_n   = dump_byte;
          rdy_n     = 1'b1;
          state_n   = S_DUMP_WAIT;
        end
      end
      S_DUMP_WAIT: begin
        if (tx_accept) begin
          if (!hdr_done) begin
            state_n = S_DUMP_RD;
          end else if (rd_addr == LAST) begin
            state_n = S_IDLE;
          end else begin
            rd_addr_n = rd_addr + 1'b1;
            state_n   = S_DUMP_RD;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// tb/tb_adc_trigger_capture.sv - randomized directed bench for adc_trigger_capture (honours ADC_CAP_HEADER_EN)
module tb_adc_trigger_capture;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
`ifdef ADC_CAP_HEADER_EN
  localparam int HOFF = 2;
`else
  localparam int HOFF = 0;
`endif
  localparam int NB = DEPTH + HOFF;

  logic       clk12 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adc_d = 8'h00;
  logic       arm = 1'b0;
  logic [7:0] trig_level = 8'h00;
  logic       trig_rising = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] sbyte;
  logic       sbyte_rdy;
  logic       busy;
  logic       armed;

  int checks = 0;
  int failures = 0;
  logic [7:0] samp[$];
  logic [7:0] expq[$];
  logic [7:0] gotq[$];

  always #5 clk12 = ~clk12;

  adc_trigger_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk12       (clk12),
    .rst_n       (rst_n),
    .adc_d       (adc_d),
    .arm         (arm),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .sbyte       (sbyte),
    .sbyte_rdy   (sbyte_rdy),
    .tx_done     (tx_done),
    .busy        (busy),
    .armed       (armed)
  );

  task automatic tick;
    @(posedge clk12);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample source per test: 0 ramp up, 1 rising blip then falling ramp, 2 no-history case, 3 random
  function automatic logic [7:0] gen(input int mode, input int k);
    logic [7:0] v;
    case (mode)
      0: v = 8'(k);
      1: v = (k == 0) ? 8'h10 : (k == 1) ? 8'h50 : 8'(255 - (k - 2));
      2: v = (k < 10) ? 8'h90 : (k == 10) ? 8'h10 : (k == 11) ? 8'h90 : 8'($urandom);
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  // Reference: first post-arm sample index whose predecessor and itself form the crossing
  function automatic int model_trig(input logic [7:0] lvl, input logic rising);
    for (int j = 1; j < samp.size(); j++) begin
      if (rising && samp[j-1] < lvl && samp[j] >= lvl) return j;
      if (!rising && samp[j-1] > lvl && samp[j] <= lvl) return j;
    end
    return -1;
  endfunction

  task automatic do_reset;
    tx_done = 1'b0;
    arm = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_sbyte", sbyte, 0);
    chk("rst_sbyte_rdy", sbyte_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_armed", armed, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic capture(input int mode, input logic [7:0] lvl, input logic rising, input logic [7:0] pre);
    int n;
    int j;
    samp.delete();
    expq.delete();
    trig_level = lvl;
    trig_rising = rising;
    adc_d = pre;
    tick;
    arm = 1'b1;
    tick;
    arm = 1'b0;
    chk("armed_after_arm", armed, 1);
    chk("busy_after_arm", busy, 1);
    n = 0;
    do begin
      adc_d = gen(mode, n);
      samp.push_back(adc_d);
      tick;
      n++;
      if (mode == 2 && n <= 11) chk("nohist_still_armed", armed, 1);
    end while (armed && n < 600);
    if (armed) begin
      chk("trigger_timeout", 0, 1);
      return;
    end
    j = model_trig(lvl, rising);
    chk("trigger_index", n - 1, j);
    repeat (DEPTH - 1) begin
      adc_d = gen(mode, n);
      samp.push_back(adc_d);
      arm = ($urandom_range(0, 15) == 0);
      tick;
      n++;
    end
    arm = 1'b0;
    chk("busy_capture_end", busy, 1);
    chk("armed_capture_end", armed, 0);
`ifdef ADC_CAP_HEADER_EN
    expq.push_back(8'hA5);
    expq.push_back(8'h5A);
`endif
    for (int k = 0; k < DEPTH; k++) begin
      expq.push_back((j >= 0 && j + k < samp.size()) ? samp[j + k] : 8'h00);
    end
  endtask

  task automatic dump(input int nb, input int stop_after, input int dmax);
    int c;
    int d;
    logic [7:0] b;
    gotq.delete();
    for (int i = 0; i < nb; i++) begin
      c = 0;
      while (!sbyte_rdy && c < 8) begin
        tick;
        c++;
      end
      chk("rdy_gap", c, 2);
      if (!sbyte_rdy) return;
      b = sbyte;
      gotq.push_back(b);
      chk("dump_byte", b, (i < expq.size()) ? expq[i] : 8'h00);
      tx_done = ($urandom_range(0, 1) == 1);
      tick;
      tx_done = 1'b0;
      chk("rdy_single", sbyte_rdy, 0);
      chk("sbyte_hold", sbyte, b);
      if (i == stop_after) return;
      d = $urandom_range(1, dmax);
      repeat (d - 1) begin
        tick;
        chk("rdy_idle", sbyte_rdy, 0);
        chk("sbyte_hold", sbyte, b);
      end
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      if (i == nb - 1) chk("busy_after_last", busy, 0);
      else chk("busy_mid_dump", busy, 1);
    end
    repeat (4) begin
      tick;
      chk("rdy_after_dump", sbyte_rdy, 0);
    end
  endtask

  initial begin
    do_reset;

    // Rising ramp through 0x80
    capture(0, 8'h80, 1'b1, 8'h00);
    dump(NB, -1, 40);
    chk("rise_count", gotq.size(), NB);
    if (gotq.size() == NB) begin
      chk("rise_first", gotq[HOFF], 8'h80);
      chk("rise_second", gotq[HOFF + 1], 8'h81);
      chk("rise_last", gotq[NB - 1], 8'h7F);
`ifdef ADC_CAP_HEADER_EN
      chk("hdr0", gotq[0], 8'hA5);
      chk("hdr1", gotq[1], 8'h5A);
`endif
    end

    // Falling ramp after an ignored rising crossing
    capture(1, 8'h40, 1'b0, 8'h00);
    dump(NB, -1, 6);
    chk("fall_count", gotq.size(), NB);
    if (gotq.size() == NB) chk("fall_first", gotq[HOFF], 8'h40);

    // Already above threshold at arm: needs a real crossing
    capture(2, 8'h80, 1'b1, 8'h90);
    dump(NB, -1, 6);
    chk("nohist_count", gotq.size(), NB);
    if (gotq.size() == NB) chk("nohist_first", gotq[HOFF], 8'h90);

    // Random data, random threshold and polarity
    capture(3, 8'($urandom_range(32, 224)), 1'($urandom_range(0, 1)), 8'($urandom));
    dump(NB, -1, 40);
    chk("rand_count", gotq.size(), NB);

    // Reset in the middle of a dump, then a fresh full capture
    capture(3, 8'($urandom_range(32, 224)), 1'($urandom_range(0, 1)), 8'($urandom));
    dump(NB, 100 + HOFF, 6);
    chk("abort_count", gotq.size(), 101 + HOFF);
    do_reset;
    capture(0, 8'h80, 1'b1, 8'h00);
    dump(NB, -1, 6);
    chk("rearm_count", gotq.size(), NB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
